operand_a_fwd_stage: RTL

- Parametrised successor to the DOF-stage ALU operand-A select. Selects operand A from NUM_SRC sources, for example register A data or PC+1 for JML.
- Adds EX/WB forwarding for the register source and load-use hazard detection.
- Registers the result into the DOF→EX pipeline boundary, with stall/flush control and a valid bit.
- Out-of-range selects produce a flagged zero instead of X.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/operand_fwd_mux.sv | 69 ++++++
 rtl/operand_a_fwd_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: forwarding source codes, source indices, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

    // Source indices for the operand-A select; index 0 is always the register file.
    localparam int SRC_REG = 0;
    localparam int SRC_PC1 = 1;

    // Which pipeline stage supplied a forwarded register operand.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_WB   = 2'd2
    } fwd_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand-A source select with EX/WB forwarding, select-range check and load-use detect.
// Latency: purely combinational.
// Backpressure: none; load_use_o tells upstream to hold the current instruction.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                     in_valid_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
    input  logic [ADDR_W-1:0]        a_addr_i,
    input  logic                     ex_wr_en_i,
    input  logic [ADDR_W-1:0]        ex_wr_addr_i,
    input  logic                     ex_is_load_i,
    input  logic [WIDTH-1:0]         ex_result_i,
    input  logic                     wb_wr_en_i,
    input  logic [ADDR_W-1:0]        wb_wr_addr_i,
    input  logic [WIDTH-1:0]         wb_data_i,
    output logic [WIDTH-1:0]         value_o,
    output fwd_e                     fwd_o,
    output logic                     err_o,
    output logic                     load_use_o
);

    logic reg_sel;
    logic a_nz;
    logic ex_match;
    logic ex_hit;
    logic wb_hit;

    // Register 0 is hard-wired, so it never takes part in forwarding or hazards.
    assign reg_sel  = (sel_i == SEL_W'(SRC_REG));
    assign a_nz     = (a_addr_i != '0);
    assign ex_match = a_nz & ex_wr_en_i & (ex_wr_addr_i == a_addr_i);
    assign ex_hit   = ex_match & ~ex_is_load_i;
    assign wb_hit   = a_nz & wb_wr_en_i & (wb_wr_addr_i == a_addr_i);

    // A load in EX has no data yet: the dependent instruction must wait one cycle.
    assign load_use_o = in_valid_i & reg_sel & ex_match & ex_is_load_i;

    // Pick the operand; out-of-range selects yield a flagged zero rather than X.
    always_comb begin
        value_o = '0;
        fwd_o   = FWD_NONE;
        err_o   = 1'b0;
        if (32'(sel_i) >= 32'(NUM_SRC)) begin
            err_o = 1'b1;
        end else if (!reg_sel) begin
            for (int i = 1; i < NUM_SRC; i++) begin
                if (sel_i == SEL_W'(i)) begin
                    value_o = src_data_i[i*WIDTH +: WIDTH];
                end
            end
        end else if (ex_hit) begin
            value_o = ex_result_i;
            fwd_o   = FWD_EX;
        end else if (wb_hit) begin
            value_o = wb_data_i;
            fwd_o   = FWD_WB;
        end else begin
            value_o = src_data_i[0 +: WIDTH];
        end
    end

endmodule

// File: rtl/operand_a_fwd_stage.sv
// DOF->EX operand-A pipeline register fed by the forwarding mux.
// Latency: 1 cycle from DOF inputs to out_*.
// Backpressure: stall_in holds the register; load-use hazards insert a bubble; flush clears.
module operand_a_fwd_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic                     ex_wr_en,
    input  logic [ADDR_W-1:0]        ex_wr_addr,
    input  logic                     ex_is_load,
    input  logic [WIDTH-1:0]         ex_result,
    input  logic                     wb_wr_en,
    input  logic [ADDR_W-1:0]        wb_wr_addr,
    input  logic [WIDTH-1:0]         wb_data,
    input  logic                     stall_in,
    input  logic                     flush,
    output logic                     load_use_stall,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [1:0]               out_fwd_src,
    output logic                     out_sel_err
);

    logic [WIDTH-1:0] mux_value;
    fwd_e             mux_fwd;
    logic             mux_err;

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [1:0]       fwd_q,   fwd_d;
    logic             err_q,   err_d;

    operand_fwd_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .ADDR_W  (ADDR_W)
    ) u_mux (
        .in_valid_i   (in_valid),
        .sel_i        (sel),
        .src_data_i   (src_data),
        .a_addr_i     (a_addr),
        .ex_wr_en_i   (ex_wr_en),
        .ex_wr_addr_i (ex_wr_addr),
        .ex_is_load_i (ex_is_load),
        .ex_result_i  (ex_result),
        .wb_wr_en_i   (wb_wr_en),
        .wb_wr_addr_i (wb_wr_addr),
        .wb_data_i    (wb_data),
        .value_o      (mux_value),
        .fwd_o        (mux_fwd),
        .err_o        (mux_err),
        .load_use_o   (load_use_stall)
    );

    // Next-state priority: flush, then hold, then bubble (hazard or no instruction), then capture.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fwd_d   = fwd_q;
        err_d   = err_q;
        if (flush || (!stall_in && (load_use_stall || !in_valid))) begin
            data_d  = '0;
            valid_d = 1'b0;
            fwd_d   = FWD_NONE;
            err_d   = 1'b0;
        end else if (!stall_in) begin
            data_d  = mux_value;
            valid_d = 1'b1;
            fwd_d   = mux_fwd;
            err_d   = mux_err;
        end
    end

    // Pipeline boundary register; synchronous reset wins over everything, including stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fwd_q   <= FWD_NONE;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fwd_q   <= fwd_d;
            err_q   <= err_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_fwd_src = fwd_q;
    assign out_sel_err = err_q;

endmodule
